// File: rtl/hs_npu_pkg.sv
// Shared types for the NPU inference datapath control blocks.
package hs_npu_pkg;

    typedef logic [15:0] uword;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_LOAD_W,
        ST_LATCH,
        ST_LOAD_IN,
        ST_LAUNCH,
        ST_DRAIN,
        ST_DONE
    } infctl_state_t;

    function automatic logic rows_legal(input uword n, input int unsigned depth);
        return (n != '0) && (32'(n) <= depth);
    endfunction

endpackage

// File: rtl/hs_npu_inference_ctrl_if.sv
// Row handshakes between the inference sequencer, its row sources, the datapath FIFOs and the result sink.
interface hs_npu_inference_ctrl_if #(
    parameter int SIZE = 8
);
    logic            weight_src_valid_i;
    logic            weight_src_ready_o;
    logic            weight_fifo_valid_o;
    logic [SIZE-1:0] weight_fifo_ready_i;
    logic            input_src_valid_i;
    logic            input_src_ready_o;
    logic            input_fifo_valid_o;
    logic [SIZE-1:0] input_fifo_ready_i;
    logic [SIZE-1:0] output_fifo_valid_i;
    logic            output_fifo_ready_o;
    logic            result_valid_o;
    logic            result_ready_i;

    modport master (
        input  weight_src_valid_i, weight_fifo_ready_i,
        input  input_src_valid_i, input_fifo_ready_i,
        input  output_fifo_valid_i, result_ready_i,
        output weight_src_ready_o, weight_fifo_valid_o,
        output input_src_ready_o, input_fifo_valid_o,
        output output_fifo_ready_o, result_valid_o
    );

    modport slave (
        output weight_src_valid_i, weight_fifo_ready_i,
        output input_src_valid_i, input_fifo_ready_i,
        output output_fifo_valid_i, result_ready_i,
        input  weight_src_ready_o, weight_fifo_valid_o,
        input  input_src_ready_o, input_fifo_valid_o,
        input  output_fifo_ready_o, result_valid_o
    );
endinterface

// File: rtl/hs_npu_inference_ctrl.sv
// Sequences one inference pass: flush, load weights, latch, load inputs, launch, drain results.
module hs_npu_inference_ctrl
    import hs_npu_pkg::*;
#(
    parameter int SIZE              = 8,
    parameter int OUTPUT_DATA_WIDTH = 32,
    parameter int INPUT_FIFO_DEPTH  = 10,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  uword                         cfg_num_rows_i,
    input  logic                         cfg_relu_i,
    input  logic [OUTPUT_DATA_WIDTH-1:0] cfg_shift_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic                         flush_input_fifos_o,
    output logic                         flush_weight_fifos_o,
    output logic                         flush_output_fifos_o,
    output logic                         enable_weights_o,
    output logic                         bias_en_o,
    output logic                         start_input_gatekeeper_o,
    output logic                         start_output_gatekeeper_o,
    output uword                         enable_cycles_o,
    output logic                         relu_enable_o,
    output logic [OUTPUT_DATA_WIDTH-1:0] shift_amount_o,
    hs_npu_inference_ctrl_if.master      hs
);

    localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam uword              SIZE_LAST = uword'(SIZE - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    infctl_state_t                r_state;
    uword                         r_n;
    logic                         r_relu;
    logic [OUTPUT_DATA_WIDTH-1:0] r_shift;
    uword                         r_xfer_cnt;
    uword                         r_pop_cnt;
    logic [TMO_W-1:0]             r_tmo;
    logic                         r_error;
    logic                         r_flush;
    logic                         r_latch;
    logic                         r_launch;
    logic                         r_done;

    infctl_state_t w_state_nxt;
    logic          w_w_fire;
    logic          w_i_fire;
    logic          w_pop;
    logic          w_in_run;
    logic          w_flush_nxt;
    logic          w_done_nxt;
    logic          w_err_set;
    logic          w_accept;

    // Row handshakes are combinational pass-throughs, live only in their own state.
    assign hs.weight_fifo_valid_o = (r_state == ST_LOAD_W) & hs.weight_src_valid_i;
    assign hs.weight_src_ready_o  = (r_state == ST_LOAD_W) & (&hs.weight_fifo_ready_i);
    assign hs.input_fifo_valid_o  = (r_state == ST_LOAD_IN) & hs.input_src_valid_i;
    assign hs.input_src_ready_o   = (r_state == ST_LOAD_IN) & (&hs.input_fifo_ready_i);
    assign hs.result_valid_o      = (r_state == ST_DRAIN) & (&hs.output_fifo_valid_i);
    assign hs.output_fifo_ready_o = hs.result_valid_o & hs.result_ready_i;

    assign w_w_fire = hs.weight_src_valid_i & hs.weight_src_ready_o;
    assign w_i_fire = hs.input_src_valid_i & hs.input_src_ready_o;
    assign w_pop    = hs.output_fifo_ready_o;
    assign w_in_run = (r_state == ST_LAUNCH) | (r_state == ST_DRAIN);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_flush_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_set   = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (rows_legal(cfg_num_rows_i, INPUT_FIFO_DEPTH)) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_err_set  = 1'b1;
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_FLUSH:  w_state_nxt = ST_LOAD_W;
            ST_LOAD_W: if (w_w_fire && r_xfer_cnt == SIZE_LAST) w_state_nxt = ST_LATCH;
            ST_LATCH:  w_state_nxt = ST_LOAD_IN;
            ST_LOAD_IN: if (w_i_fire && r_xfer_cnt == r_n - uword'(1)) w_state_nxt = ST_LAUNCH;
            ST_LAUNCH: w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                // A final pop in the same cycle as the timeout still completes the pass.
                if (w_pop && r_pop_cnt == r_n - uword'(1)) begin
                    w_state_nxt = ST_DONE;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_err_set   = 1'b1;
                    w_flush_nxt = 1'b1;
                    w_done_nxt  = 1'b1;
                end
            end
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (abort_i && r_state != ST_IDLE) begin
            w_state_nxt = ST_IDLE;
            w_flush_nxt = 1'b1;
            w_done_nxt  = 1'b0;
            w_err_set   = 1'b0;
        end
        w_flush_nxt = w_flush_nxt | (w_state_nxt == ST_FLUSH);
        w_done_nxt  = w_done_nxt | (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_n        <= '0;
            r_relu     <= 1'b0;
            r_shift    <= '0;
            r_xfer_cnt <= '0;
            r_pop_cnt  <= '0;
            r_tmo      <= '0;
            r_error    <= 1'b0;
            r_flush    <= 1'b0;
            r_latch    <= 1'b0;
            r_launch   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here, so every register sees pre-edge values.
            r_state  <= w_state_nxt;
            r_flush  <= w_flush_nxt;
            r_latch  <= (w_state_nxt == ST_LATCH);
            r_launch <= (w_state_nxt == ST_LAUNCH);
            r_done   <= w_done_nxt;
            if (w_err_set)     r_error <= 1'b1;
            else if (w_accept) r_error <= 1'b0;
            if (w_accept) begin
                r_n     <= cfg_num_rows_i;
                r_relu  <= cfg_relu_i;
                r_shift <= cfg_shift_i;
            end
            // One counter serves both load phases; it restarts on every state change.
            if (w_state_nxt != r_state)   r_xfer_cnt <= '0;
            else if (w_w_fire | w_i_fire) r_xfer_cnt <= r_xfer_cnt + uword'(1);
            if (r_state != ST_DRAIN) r_pop_cnt <= '0;
            else if (w_pop)          r_pop_cnt <= r_pop_cnt + uword'(1);
            if (w_in_run) r_tmo <= r_tmo + TMO_W'(1);
            else          r_tmo <= '0;
        end
    end

    assign busy_o                    = (r_state != ST_IDLE);
    assign done_o                    = r_done;
    assign error_o                   = r_error;
    assign flush_input_fifos_o       = r_flush;
    assign flush_weight_fifos_o      = r_flush;
    assign flush_output_fifos_o      = r_flush;
    assign enable_weights_o          = r_latch;
    assign bias_en_o                 = r_latch;
    assign start_input_gatekeeper_o  = r_launch;
    assign start_output_gatekeeper_o = r_launch;
    assign enable_cycles_o           = w_in_run ? r_n + SIZE_LAST : '0;
    assign relu_enable_o             = r_relu;
    assign shift_amount_o            = r_shift;

endmodule
